// File: rtl/keypad_pkg.sv
// Shared types and defaults for the keypad scanner and its downstream digit updater.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [3:0] COL_INIT             = 4'b1110;
    localparam int         SCAN_DIV_DEF         = 2500;
    localparam int         DEBOUNCE_CYCLES_DEF  = 50000;

    // Lowest set bit wins when several rows are seen in one column.
    function automatic logic [3:0] lowest_bit(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    function automatic logic [3:0] next_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the accepted-key outputs; master is the scanner side.
interface keypad_scanner_if;
    logic [3:0] rows_n;
    logic [3:0] cols_n;
    logic [3:0] row;
    logic [3:0] col;
    logic       en;

    modport master (input rows_n, output cols_n, output row, output col, output en);
    modport slave  (output rows_n, input cols_n, input row, input col, input en);
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer, asynchronous reset to 0.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce; presents held key as one-hot row/col + level en.
// Press-to-en is DEBOUNCE_CYCLES after debounce entry; release-to-drop is DEBOUNCE_CYCLES after first released sample.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    // The released sample that left HELD already counts toward the release window.
    localparam logic [DW-1:0] REL_LAST  = DW'(DEBOUNCE_CYCLES - 2);

    logic [3:0]    pressed;
    state_t        state, state_nxt;
    logic [SW-1:0] scan_cnt, scan_cnt_nxt;
    logic [DW-1:0] deb_cnt, deb_cnt_nxt;
    logic [3:0]    cols_q, cols_nxt;
    logic [3:0]    cand_row, cand_row_nxt;
    logic [3:0]    cand_col, cand_col_nxt;
    logic [3:0]    row_q, row_nxt;
    logic [3:0]    col_q, col_nxt;
    logic          en_q, en_nxt;
    logic          cand_hit;

    sync2 #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (reset),
        .d   (~kp.rows_n),
        .q   (pressed)
    );

    assign cand_hit  = |(pressed & cand_row);
    assign kp.cols_n = cols_q;
    assign kp.row    = row_q;
    assign kp.col    = col_q;
    assign kp.en     = en_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SCAN;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            cols_q   <= COL_INIT;
            cand_row <= '0;
            cand_col <= '0;
            row_q    <= '0;
            col_q    <= '0;
            en_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            scan_cnt <= scan_cnt_nxt;
            deb_cnt  <= deb_cnt_nxt;
            cols_q   <= cols_nxt;
            cand_row <= cand_row_nxt;
            cand_col <= cand_col_nxt;
            row_q    <= row_nxt;
            col_q    <= col_nxt;
            en_q     <= en_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        scan_cnt_nxt = scan_cnt;
        deb_cnt_nxt  = deb_cnt;
        cols_nxt     = cols_q;
        cand_row_nxt = cand_row;
        cand_col_nxt = cand_col;
        row_nxt      = row_q;
        col_nxt      = col_q;
        en_nxt       = en_q;

        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_nxt = '0;
                    if (pressed == 4'b0000) begin
                        cols_nxt = next_col(cols_q);
                    end else begin
                        cand_row_nxt = lowest_bit(pressed);
                        cand_col_nxt = ~cols_q;
                        deb_cnt_nxt  = '0;
                        state_nxt    = DEBOUNCE;
                    end
                end else begin
                    scan_cnt_nxt = scan_cnt + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (!cand_hit) begin
                    state_nxt    = SCAN;
                    scan_cnt_nxt = '0;
                    cols_nxt     = next_col(cols_q);
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt   = HELD;
                    deb_cnt_nxt = '0;
                    row_nxt     = cand_row;
                    col_nxt     = cand_col;
                    en_nxt      = 1'b1;
                end else begin
                    deb_cnt_nxt = deb_cnt + DW'(1);
                end
            end
            HELD: begin
                if (!cand_hit) begin
                    state_nxt   = RELEASE;
                    deb_cnt_nxt = '0;
                end
            end
            RELEASE: begin
                if (cand_hit) begin
                    state_nxt   = HELD;
                    deb_cnt_nxt = '0;
                end else if (deb_cnt == REL_LAST) begin
                    state_nxt    = SCAN;
                    scan_cnt_nxt = '0;
                    deb_cnt_nxt  = '0;
                    cols_nxt     = next_col(cols_q);
                    row_nxt      = '0;
                    col_nxt      = '0;
                    en_nxt       = 1'b0;
                end else begin
                    deb_cnt_nxt = deb_cnt + DW'(1);
                end
            end
            default: state_nxt = SCAN;
        endcase
    end
endmodule
